// File: rtl/sync_fifo_rd_stream.sv
// sync_fifo_rd_stream: read side of sync_fifo_ptr,
// re-presented as a valid/ready stream.
//
// Ports:
//   clk, rst_n       clock, sync active-low reset
//   fifo_empty       FIFO empty flag (registered)
//   fifo_data_out    FIFO read data, valid the edge
//                    after an accepted fifo_rd_en
//   fifo_rd_en       FIFO read strobe
//   m_valid/m_ready  stream handshake
//   m_data           stream word
//   m_level          words held in the output buffer
//   beat_cnt         words delivered
//   stall_cnt        cycles with m_valid & ~m_ready
//
// Build option: SYNC_FIFO_RD_STREAM_STATS_EN enables
// the beat/stall counters; otherwise they read 0.

module sync_fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            m_level,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  logic [DATA_WIDTH-1:0] mem [3];
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            cnt;
  logic                  inflight;
  logic                  pop;
  logic [2:0]            occ;

  function automatic logic [1:0] ptr_next(
    input logic [1:0] p
  );
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // A slot is reserved for every read in flight,
  // so issuing only while occ < 3 means a returning
  // word always has room. Issue never looks at
  // m_ready, keeping the consumer off this path.
  assign occ = 3'(cnt) + 3'(inflight);

  assign fifo_rd_en = rst_n & ~fifo_empty
                    & (occ < 3'd3);

  assign m_valid = (cnt != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_level = cnt;

  always_comb begin
    m_data = mem[0];
    unique case (rd_ptr)
      2'd1:    m_data = mem[1];
      2'd2:    m_data = mem[2];
      default: m_data = mem[0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= 2'd0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight)
        wr_ptr <= ptr_next(wr_ptr);
      if (pop)
        rd_ptr <= ptr_next(rd_ptr);
      cnt <= cnt + 2'(inflight) - 2'(pop);
    end
  end

  // Storage needs no reset; cnt gates visibility.
  always_ff @(posedge clk) begin
    if (rst_n && inflight) begin
      unique case (wr_ptr)
        2'd1:    mem[1] <= fifo_data_out;
        2'd2:    mem[2] <= fifo_data_out;
        default: mem[0] <= fifo_data_out;
      endcase
    end
  end

`ifdef SYNC_FIFO_RD_STREAM_STATS_EN
  logic [CNT_WIDTH-1:0] beat_q;
  logic [CNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      if (pop)
        beat_q <= beat_q + CNT_WIDTH'(1);
      if (m_valid && !m_ready)
        stall_q <= stall_q + CNT_WIDTH'(1);
    end
  end

  assign beat_cnt  = beat_q;
  assign stall_cnt = stall_q;
`else
  assign beat_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Bench for sync_fifo_rd_stream with a queue-based
// FIFO model and a scoreboard of written words.

module tb_sync_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [1:0]    m_level;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  sync_fifo_rd_stream #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fifo_empty(fifo_empty),
    .fifo_data_out(fifo_data_out),
    .fifo_rd_en(fifo_rd_en),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_level(m_level),
    .beat_cnt(beat_cnt),
    .stall_cnt(stall_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  // FIFO model: registered empty and data_out
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      fq.delete();
      fifo_empty    <= 1'b1;
      fifo_data_out <= '0;
    end else begin
      if (fifo_rd_en && !fifo_empty)
        fifo_data_out <= fq.pop_front();
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Reference: words issued minus words popped
  bit            chk_en = 1'b0;
  int            outstanding = 0;
  int            last_iss = 0;
  int            pop_total = 0;
  bit            held = 1'b0;
  logic [DW-1:0] held_d;
  logic [CW-1:0] beat_exp = '0;
  logic [CW-1:0] stall_exp = '0;

  always @(posedge clk) begin
    if (chk_en) begin
      chk("rd_en_rule", 32'(fifo_rd_en),
          32'(rst_n && !fifo_empty
              && outstanding < 3));
      chk("level", 32'(m_level),
          32'(outstanding - last_iss));
      chk("valid", 32'(m_valid),
          32'((outstanding - last_iss) != 0));
      chk("occ_inv",
          32'(int'(dut.cnt) + int'(dut.inflight)
              <= 3), 32'd1);
      chk("wr_ptr_rng", 32'(dut.wr_ptr != 2'd3),
          32'd1);
      chk("rd_ptr_rng", 32'(dut.rd_ptr != 2'd3),
          32'd1);
      if (held) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(held_d));
      end
`ifdef SYNC_FIFO_RD_STREAM_STATS_EN
      chk("beat_cnt", 32'(beat_cnt), 32'(beat_exp));
      chk("stall_cnt", 32'(stall_cnt),
          32'(stall_exp));
`else
      chk("beat_cnt", 32'(beat_cnt), 32'd0);
      chk("stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    end
    if (!rst_n) begin
      outstanding = 0;
      last_iss = 0;
      held = 1'b0;
      beat_exp = '0;
      stall_exp = '0;
      exp_q.delete();
    end else begin
      held = 1'b0;
      if (m_valid && m_ready) begin
        pop_total++;
        beat_exp = beat_exp + CW'(1);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL order: got %0h want none",
                   m_data);
        end else begin
          chk("order", 32'(m_data),
              32'(exp_q.pop_front()));
        end
      end
      if (m_valid && !m_ready) begin
        stall_exp = stall_exp + CW'(1);
        held = 1'b1;
        held_d = m_data;
      end
      outstanding += int'(fifo_rd_en)
                   - int'(m_valid && m_ready);
      last_iss = int'(fifo_rd_en);
    end
  end

  task automatic load_cyc(input int n,
                          input logic [7:0] base,
                          input bit rdy);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + 8'(i));
      exp_q.push_back(base + 8'(i));
    end
    m_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit rdy);
    load_cyc(0, 8'h00, rdy);
  endtask

  typedef struct {
    bit         wr;
    logic [7:0] d;
    bit         rdy;
    bit         e_rd;
    bit         e_vld;
    logic [1:0] e_lvl;
    logic [7:0] e_dat;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int pulses, rd_cnt, pops, first, last, k, n, pt0;

    // single word, then backpressure fill
    tbl[0]  = '{1, 8'hAA, 1, 1, 0, 2'd0, 8'h00};
    tbl[1]  = '{0, 8'h00, 1, 0, 0, 2'd0, 8'h00};
    tbl[2]  = '{0, 8'h00, 1, 0, 1, 2'd1, 8'hAA};
    tbl[3]  = '{0, 8'h00, 1, 0, 0, 2'd0, 8'h00};
    tbl[4]  = '{0, 8'h00, 0, 0, 0, 2'd0, 8'h00};
    tbl[5]  = '{1, 8'h10, 0, 1, 0, 2'd0, 8'h00};
    tbl[6]  = '{1, 8'h11, 0, 1, 0, 2'd0, 8'h00};
    tbl[7]  = '{1, 8'h12, 0, 1, 1, 2'd1, 8'h10};
    tbl[8]  = '{1, 8'h13, 0, 0, 1, 2'd2, 8'h10};
    tbl[9]  = '{1, 8'h14, 0, 0, 1, 2'd3, 8'h10};
    tbl[10] = '{1, 8'h15, 0, 0, 1, 2'd3, 8'h10};
    tbl[11] = '{1, 8'h16, 0, 0, 1, 2'd3, 8'h10};
    tbl[12] = '{1, 8'h17, 0, 0, 1, 2'd3, 8'h10};
    tbl[13] = '{0, 8'h00, 0, 0, 1, 2'd3, 8'h10};
    tbl[14] = '{0, 8'h00, 0, 0, 1, 2'd3, 8'h10};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(m_level), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_beat", 32'(beat_cnt), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      load_cyc(tbl[i].wr ? 1 : 0, tbl[i].d,
               tbl[i].rdy);
      chk($sformatf("vec%0d_rd_en", i),
          32'(fifo_rd_en), 32'(tbl[i].e_rd));
      chk($sformatf("vec%0d_valid", i),
          32'(m_valid), 32'(tbl[i].e_vld));
      chk($sformatf("vec%0d_level", i),
          32'(m_level), 32'(tbl[i].e_lvl));
      if (tbl[i].e_vld)
        chk($sformatf("vec%0d_data", i),
            32'(m_data), 32'(tbl[i].e_dat));
      if (i >= 5 && fifo_rd_en) pulses++;
    end
    chk("bp_pulses", 32'(pulses), 32'd3);

    // drain with m_ready toggling
    for (int i = 0; i < 24; i++)
      cyc(i % 2 == 0);
    chk("toggle_drained", 32'(exp_q.size()), 32'd0);
    chk("toggle_level", 32'(m_level), 32'd0);

    // streaming 0x00..0x0F
    load_cyc(16, 8'h00, 1);
    rd_cnt = int'(fifo_rd_en);
    pops = 0;
    first = -1;
    last = -1;
    for (int i = 0; i < 30; i++) begin
      if (m_valid && m_ready) begin
        pops++;
        if (first < 0) first = i;
        last = i;
      end
      cyc(1);
      rd_cnt += int'(fifo_rd_en);
    end
    chk("stream_rd_cycles", 32'(rd_cnt), 32'd16);
    chk("stream_beats", 32'(pops), 32'd16);
    chk("stream_gapless", 32'(last - first),
        32'd15);

    // push and pop on the same edge
    load_cyc(2, 8'h21, 1);
    cyc(1);
    cyc(1);
    chk("pp_level_before", 32'(m_level), 32'd1);
    chk("pp_inflight", 32'(dut.inflight), 32'd1);
    chk("pp_data_before", 32'(m_data), 32'h21);
    cyc(1);
    chk("pp_level_after", 32'(m_level), 32'd1);
    chk("pp_data_after", 32'(m_data), 32'h22);
    repeat (3) cyc(1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) begin
          k = $urandom_range(0, 255);
          fq.push_back(8'(k));
          exp_q.push_back(8'(k));
        end
      end
      m_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #1;
    end
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      cyc(1);
      k++;
    end
    repeat (3) cyc(1);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("rand_level", 32'(m_level), 32'd0);

    // stats: 5 beats, 4 stall cycles
    @(negedge clk);
    rst_n = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_cyc(5, 8'h40, 0);
    k = 0;
    while (!m_valid && k < 10) begin
      cyc(0);
      k++;
    end
    chk("stats_valid_seen", 32'(m_valid), 32'd1);
    repeat (4) cyc(0);
    repeat (12) cyc(1);
    chk("stats_drained", 32'(exp_q.size()), 32'd0);
`ifdef SYNC_FIFO_RD_STREAM_STATS_EN
    chk("stats_beats", 32'(beat_cnt), 32'd5);
    chk("stats_stalls", 32'(stall_cnt), 32'd4);
`else
    chk("stats_beats", 32'(beat_cnt), 32'd0);
    chk("stats_stalls", 32'(stall_cnt), 32'd0);
`endif

    // reset with level 2 and a read in flight
    load_cyc(4, 8'h30, 0);
    repeat (3) cyc(0);
    chk("mid_level", 32'(m_level), 32'd2);
    chk("mid_inflight", 32'(dut.inflight), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_level", 32'(m_level), 32'd0);
    chk("mid_rst_rd_en2", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pt0 = pop_total;
    load_cyc(1, 8'h55, 1);
    repeat (6) cyc(1);
    chk("post_rst_beats", 32'(pop_total - pt0),
        32'd1);
    chk("post_rst_drained", 32'(exp_q.size()),
        32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_rd_stream.md
Name: sync_fifo_rd_stream

Overview:
- Read-side companion for the `sync_fifo_ptr` FIFO.
- Drives the FIFO's `rd_en` and consumes its registered `data_out`/`empty`.
- Re-presents the words as a valid/ready stream for downstream consumers.
- Absorbs the FIFO's 1-cycle read latency with a 3-entry circular output buffer. This sustains 1 word/cycle with no combinational path from `m_ready` to `fifo_rd_en`.

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO.
- CNT_WIDTH, 16, width of the optional statistics counters.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- fifo_empty  input  1  FIFO `empty` flag
- fifo_data_out  input  DATA_WIDTH  FIFO `data_out`; valid on the edge following an accepted `rd_en`
- fifo_rd_en  output  1  FIFO read strobe
- m_valid  output  1  stream word available
- m_ready  input  1  consumer accepts word
- m_data  output  DATA_WIDTH  stream word
- m_level  output  2  words held in the output buffer (0..3)
- beat_cnt  output  CNT_WIDTH  words delivered; see Optional Feature
- stall_cnt  output  CNT_WIDTH  stall cycles; see Optional Feature

Behaviour:
- State registers:
  - buf[0..2]
  - wr_ptr, rd_ptr: 2 bits each, range 0..2, wrap 2->0
  - cnt: 0..3
  - inflight: 1 bit
- Reset (rst_n=0 at an edge):
  - cnt=0, wr_ptr=0, rd_ptr=0, inflight=0.
  - m_valid=0, fifo_rd_en=0, m_level=0, beat_cnt=0, stall_cnt=0.
  - buf contents are don't-care.
- While rst_n=0, fifo_rd_en is forced 0.
- Read issue (combinational from registers and fifo_empty only):
  - fifo_rd_en = rst_n & ~fifo_empty & ((cnt + inflight) < 3).
- Read return:
  - inflight <= fifo_rd_en at every edge.
  - When inflight=1 at an edge: buf[wr_ptr] <= fifo_data_out, then wr_ptr advances mod 3.
- Pop:
  - pop = m_valid & m_ready.
  - On pop, rd_ptr advances mod 3.
- Stream outputs:
  - m_valid = (cnt != 0).
  - m_data = buf[rd_ptr].
  - m_data is held stable while m_valid=1 and m_ready=0.
- Buffer count: cnt <= cnt + inflight - pop.
  - Simultaneous push and pop leaves cnt unchanged.
  - m_level = cnt.
- Invariant: cnt + inflight <= 3. Overflow of buf is impossible by construction.
  - The bench asserts this invariant.
  - The bench asserts that wr_ptr and rd_ptr never take value 3.
- Latency:
  - Word written to an empty FIFO with an idle adapter: fifo_empty falls at edge E.
  - fifo_rd_en is high in cycle E..E+1.
  - Data is captured at E+2, and m_valid is high after E+2.
  - So m_valid rises 2 edges after fifo_empty falls.
- Throughput:
  - With FIFO non-empty and m_ready held 1, one beat per cycle in steady state.
  - fifo_rd_en stays high continuously.
- Boundaries:
  - Backpressure: with m_ready=0, exactly 3 reads are issued, then fifo_rd_en=0 until a pop.
  - FIFO runs empty: fifo_rd_en drops the same cycle. Buffered words still drain.
  - Reset mid-operation: an in-flight read word is discarded and buffered words are lost. This is documented data loss; the FIFO must be reset together with this block.
- Ordering: words leave in exactly FIFO order, with no duplication or drop outside reset.

Optional Feature:
- Macro: SYNC_FIFO_RD_STREAM_STATS_EN
- Defined:
  - beat_cnt increments on each pop.
  - stall_cnt increments each cycle with m_valid=1 and m_ready=0.
  - Both counters wrap at 2^CNT_WIDTH and clear on reset.
- Undefined:
  - beat_cnt and stall_cnt are tied to constant 0.
  - No counter registers are synthesized.
  - All other behaviour is identical.

Test Plan:
- Single word:
  - Stimulus: FIFO write 0xAA, m_ready=1.
  - Required: m_valid rises 2 edges after fifo_empty falls, with m_data=0xAA. Exactly one beat. m_level returns to 0.
- Streaming:
  - Stimulus: fill FIFO with 0x00..0x0F, m_ready=1.
  - Required: 16 consecutive beats 0x00..0x0F with no gaps after the first. fifo_rd_en high for exactly 16 cycles.
- Backpressure/wrap:
  - Stimulus: FIFO holds 0x10..0x17, m_ready=0 for 10 cycles.
  - Required: exactly 3 fifo_rd_en pulses, m_level=3, m_data stable at 0x10.
  - Then toggle m_ready 1/0 every cycle. Required: 0x10..0x17 in order, pointers wrap correctly.
- Simultaneous push/pop:
  - Stimulus: m_level=1 while a read is in flight, and a pop occurs the same edge.
  - Required: m_level stays 1, next m_data is the in-flight word.
- Reset mid-stream:
  - Stimulus: assert rst_n=0 for 1 edge with m_level=2 and inflight=1.
  - Required: m_valid=0, m_level=0, fifo_rd_en=0 during reset. After release and a fresh FIFO reset, write 0x55 -> single beat 0x55.
- Stats (macro defined):
  - Stimulus: 5 beats, with m_ready=0 for 4 cycles while m_valid=1.
  - Required: beat_cnt=5, stall_cnt=4.
  - With the macro undefined: both counters read 0.
